inst_fetch_req: RTL and testbench
=================================

# inst_fetch_req

Instruction-fetch initiator for the Sophon core. It runs on the negative-edge core clock and drives the core channel of the IRAM arbiter using the `inst_req_t`/`inst_ack_t` protocol. It absorbs arbiter stalls caused by external IRAM accesses and buffers fetched words in a small queue toward decode. It also supports PC redirects that flush any fetches already in flight.

## Interface
- `BOOT_ADDR`, default 32'h8000_0000: PC after reset. Bits [1:0] are ignored.
- `FIFO_DEPTH`, default 2: instruction-queue entries. Legal values are 2 to 4.

- `clk_neg_i`  in  1: core clock (negative-edge domain). All state changes on its rising edge.
- `rst_neg_ni`  in  1: reset, asynchronous, active-low.
- `fetch_en_i`  in  1: permits new requests.
- `redirect_i`  in  1: flush and reload the PC.
- `redirect_pc_i`  in  32: new PC. Bits [1:0] are forced to 0.
- `inst_req_o`  out  `SOPHON_PKG::inst_req_t`: fields `.req` and `.addr`.
- `inst_ack_i`  in  `SOPHON_PKG::inst_ack_t`: fields `.ack` (combinational, same cycle as `.req`), `.error`, and `.rdata` (valid the cycle after acceptance).
- `ifq_valid_o`  out  1: queue head is valid.
- `ifq_ready_i`  in  1: decode consumes the head.
- `ifq_inst_o`  out  32: head instruction word.
- `ifq_pc_o`  out  32: head PC.
- `ifq_err_o`  out  1: head fetch error.
- `busy_o`  out  1: a fetch is pending or the queue is non-empty.

## Operation
- **State registers:** `pc_q`, `pend_q`, `pend_pc_q`, `pend_err_q`, a queue of `{inst, pc, err}`, and `occ_q`.
- **Issue condition:** `.req` = `fetch_en_i & ~redirect_i & (occ_q + pend_q - pop < FIFO_DEPTH)`, where `pop = ifq_valid_o & ifq_ready_i`.
- **Request address:** `.addr` = `pc_q` whenever `.req` is high.
- **Accept** (`.req & .ack`):
  - `pc_q` += 4, wrapping modulo 2^32 (32'hFFFF_FFFC → 0).
  - `pend_q` <= 1.
  - `pend_pc_q` <= `pc_q`.
  - `pend_err_q` <= `.error` (see Configuration).
- **Stall** (`.req & ~.ack`): `pc_q` holds, and `.req`/`.addr` are re-presented unchanged on the next cycle. There is no timeout. A stall lasting two or more cycles is normal.
- **Return:** in the cycle with `pend_q`=1, push `{.rdata, pend_pc_q, pend_err_q}`. `pend_q` clears unless a new accept occurs in the same cycle.
- **Queue behaviour:**
  - FIFO order.
  - Push and pop in the same cycle are legal at any occupancy, including full.
  - Overflow cannot occur because of the credit rule.
  - Popping an empty queue is ignored.
- **Redirect** (takes priority over all other events):
  - `pc_q` <= `redirect_pc_i & ~3`.
  - `occ_q` <= 0.
  - `pend_q` <= 0, so the returning `.rdata` is discarded.
  - `.req` = 0 in that cycle.
- **`fetch_en_i` deasserted:** no new requests. A pending return still completes and the queue keeps draining.
- **Reset values:**
  - `.req` 0, `.addr` `BOOT_ADDR`.
  - `ifq_valid_o` 0, `ifq_inst_o` 0, `ifq_pc_o` 0, `ifq_err_o` 0, `busy_o` 0.
  - `pc_q` = `BOOT_ADDR`.
- **Reset mid-operation:** all state is discarded immediately (asynchronously). Any in-flight data is dropped.

## Timing
- **Fetch latency:** accept in cycle N → data in queue, `ifq_valid_o`=1, in N+2.
- **Throughput:** one fetch per cycle with `ifq_ready_i`=1 and no stall.
- **Redirect in cycle R:** first new request in R+1, and its instruction is visible no earlier than R+3. `ifq_valid_o`=0 in R+1.
- **Stall cycles:** each stall cycle adds exactly one cycle of latency. The sequence of presented addresses stays contiguous.
- **Combinational paths:** `.req` depends on `ifq_ready_i`. Neither `inst_ack_i` nor `ifq_ready_i` combinationally drives `.addr`.

## Configuration
- `INST_FETCH_ERR_EN` defined:
  - `.error` is sampled at accept and carried to `ifq_err_o`.
  - An errored entry still returns `.rdata`, and fetching continues.
- `INST_FETCH_ERR_EN` undefined:
  - The error path is removed, `ifq_err_o` is tied 0, and `.error` is ignored.

## Test plan
- **Reset sequence:** reset release, `fetch_en_i`=1, `.ack` always 1 → `.addr` sequence 8000_0000, 8000_0004, …; first `ifq_valid_o` two cycles after the first accept with `ifq_pc_o`=8000_0000.
- **Stall:** `.ack` held 0 for 2 cycles at addr 8000_0008 → `.req` stays high with `.addr` stable at 8000_0008; queue order is unbroken and no PC is skipped or duplicated.
- **Backpressure:** `ifq_ready_i`=0 → occupancy saturates at `FIFO_DEPTH` with no further `.req`. Raising ready → 1 pop/cycle resumes with no lost entries.
- **Redirect with fetch in flight:** redirect to 0000_0102 one cycle after an accept → returning data dropped, queue empty, next `.addr`=0000_0100.
- **PC wrap:** redirect to FFFF_FFFC, ack 1 → consecutive entries with PC FFFF_FFFC then 0000_0000.
- **Error propagation:** `.error`=1 on the accept at 8000_0010 → with `INST_FETCH_ERR_EN` defined, that entry has `ifq_err_o`=1 and its neighbours have 0; with the macro undefined, `ifq_err_o` is always 0.

Source files
------------

// File: rtl/inst_fetch_req.sv
// Sophon instruction-fetch initiator: drives the IRAM arbiter core channel and queues fetched words.
// Optional macro INST_FETCH_ERR_EN carries the bus error flag through to ifq_err_o.

package SOPHON_PKG;
  typedef struct packed {
    logic        req;
    logic [31:0] addr;
  } inst_req_t;

  typedef struct packed {
    logic        ack;
    logic        error;
    logic [31:0] rdata;
  } inst_ack_t;
endpackage

module inst_fetch_req #(
  parameter logic [31:0] BOOT_ADDR  = 32'h8000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                  clk_neg_i,
  input  logic                  rst_neg_ni,
  input  logic                  fetch_en_i,
  input  logic                  redirect_i,
  input  logic [31:0]           redirect_pc_i,
  output SOPHON_PKG::inst_req_t inst_req_o,
  input  SOPHON_PKG::inst_ack_t inst_ack_i,
  output logic                  ifq_valid_o,
  input  logic                  ifq_ready_i,
  output logic [31:0]           ifq_inst_o,
  output logic [31:0]           ifq_pc_o,
  output logic                  ifq_err_o,
  output logic                  busy_o
);

  localparam logic [31:0] BOOT_PC  = {BOOT_ADDR[31:2], 2'b00};
  localparam logic [2:0]  DEPTH_C  = 3'(FIFO_DEPTH);
  localparam logic [1:0]  LAST_PTR = 2'(FIFO_DEPTH - 1);

  logic [31:0] pc_r;
  logic [31:0] pend_pc_r;
  logic        pend_r;
  logic [1:0]  head_r;
  logic [1:0]  tail_r;
  logic [2:0]  occ_r;
  logic [31:0] inst_mem_r [4];
  logic [31:0] pc_mem_r   [4];

  logic        pop_s;
  logic        push_s;
  logic        req_s;
  logic        accept_s;
  logic [2:0]  credit_s;
  logic [2:0]  occ_next_s;

  function automatic logic [1:0] ptr_inc(input logic [1:0] ptr);
    if (ptr == LAST_PTR) begin
      return 2'd0;
    end else begin
      return ptr + 2'd1;
    end
  endfunction

  // Credit check counts the in-flight fetch so the queue can never overflow
  always_comb begin
    pop_s      = (occ_r != 3'd0) & ifq_ready_i;
    push_s     = pend_r & ~redirect_i;
    credit_s   = occ_r + {2'b00, pend_r} - {2'b00, pop_s};
    req_s      = fetch_en_i & ~redirect_i & (credit_s < DEPTH_C);
    accept_s   = req_s & inst_ack_i.ack;
    occ_next_s = occ_r + {2'b00, push_s} - {2'b00, pop_s};
  end

  // PC, outstanding-fetch tracking and queue pointers; redirect overrides everything
  always_ff @(posedge clk_neg_i or negedge rst_neg_ni) begin
    if (!rst_neg_ni) begin
      pc_r      <= BOOT_PC;
      pend_r    <= 1'b0;
      pend_pc_r <= 32'd0;
      head_r    <= 2'd0;
      tail_r    <= 2'd0;
      occ_r     <= 3'd0;
    end else if (redirect_i) begin
      pc_r   <= {redirect_pc_i[31:2], 2'b00};
      pend_r <= 1'b0;
      head_r <= 2'd0;
      tail_r <= 2'd0;
      occ_r  <= 3'd0;
    end else begin
      pend_r <= accept_s;
      if (accept_s) begin
        pc_r      <= pc_r + 32'd4;
        pend_pc_r <= pc_r;
      end
      if (push_s) begin
        tail_r <= ptr_inc(tail_r);
      end
      if (pop_s) begin
        head_r <= ptr_inc(head_r);
      end
      occ_r <= occ_next_s;
    end
  end

  // Queue storage for returned words and their PCs
  always_ff @(posedge clk_neg_i or negedge rst_neg_ni) begin
    if (!rst_neg_ni) begin
      for (int i = 0; i < 4; i++) begin
        inst_mem_r[i] <= 32'd0;
        pc_mem_r[i]   <= 32'd0;
      end
    end else if (push_s) begin
      inst_mem_r[tail_r] <= inst_ack_i.rdata;
      pc_mem_r[tail_r]   <= pend_pc_r;
    end
  end

`ifdef INST_FETCH_ERR_EN
  logic       pend_err_r;
  logic [3:0] err_mem_r;

  // Error flag captured at accept and queued alongside its word
  always_ff @(posedge clk_neg_i or negedge rst_neg_ni) begin
    if (!rst_neg_ni) begin
      pend_err_r <= 1'b0;
      err_mem_r  <= 4'd0;
    end else begin
      if (accept_s && !redirect_i) begin
        pend_err_r <= inst_ack_i.error;
      end
      if (push_s) begin
        err_mem_r[tail_r] <= pend_err_r;
      end
    end
  end

  assign ifq_err_o = ifq_valid_o & err_mem_r[head_r];
`else
  logic unused_err_s;
  assign unused_err_s = inst_ack_i.error;
  assign ifq_err_o    = 1'b0;
`endif

  // Head of queue is masked to zero when empty
  always_comb begin
    ifq_valid_o = (occ_r != 3'd0);
    busy_o      = pend_r | (occ_r != 3'd0);
    if (ifq_valid_o) begin
      ifq_inst_o = inst_mem_r[head_r];
      ifq_pc_o   = pc_mem_r[head_r];
    end else begin
      ifq_inst_o = 32'd0;
      ifq_pc_o   = 32'd0;
    end
  end

  assign inst_req_o.req  = req_s;
  assign inst_req_o.addr = pc_r;

endmodule

// File: tb/tb_inst_fetch_req.sv
// Directed bench for inst_fetch_req: boot fetch, stall, backpressure, redirect, PC wrap and error flag.
module tb_inst_fetch_req;

  logic                  clk_neg_i;
  logic                  rst_neg_ni;
  logic                  fetch_en_i;
  logic                  redirect_i;
  logic [31:0]           redirect_pc_i;
  SOPHON_PKG::inst_req_t inst_req_o;
  SOPHON_PKG::inst_ack_t inst_ack_i;
  logic                  ifq_valid_o;
  logic                  ifq_ready_i;
  logic [31:0]           ifq_inst_o;
  logic [31:0]           ifq_pc_o;
  logic                  ifq_err_o;
  logic                  busy_o;

  int tests_run;
  int tests_failed;

  logic        acc_prev;
  logic [31:0] acc_addr;

`ifdef INST_FETCH_ERR_EN
  localparam logic [31:0] ERR_EXP = 32'd1;
`else
  localparam logic [31:0] ERR_EXP = 32'd0;
`endif

  inst_fetch_req dut (
    .clk_neg_i    (clk_neg_i),
    .rst_neg_ni   (rst_neg_ni),
    .fetch_en_i   (fetch_en_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .inst_req_o   (inst_req_o),
    .inst_ack_i   (inst_ack_i),
    .ifq_valid_o  (ifq_valid_o),
    .ifq_ready_i  (ifq_ready_i),
    .ifq_inst_o   (ifq_inst_o),
    .ifq_pc_o     (ifq_pc_o),
    .ifq_err_o    (ifq_err_o),
    .busy_o       (busy_o)
  );

  initial clk_neg_i = 1'b0;
  always #5 clk_neg_i = ~clk_neg_i;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One bus cycle: drive at the falling edge, settle, remember any accept for next cycle's rdata
  task automatic step(input logic en, input logic rdr, input logic [31:0] rpc,
                      input logic ack, input logic err, input logic rdy);
    @(negedge clk_neg_i);
    fetch_en_i           = en;
    redirect_i           = rdr;
    redirect_pc_i        = rpc;
    inst_ack_i.ack       = ack;
    inst_ack_i.error     = err;
    inst_ack_i.rdata     = acc_prev ? inst_of(acc_addr) : 32'hDEAD_BEEF;
    ifq_ready_i          = rdy;
    #1;
    acc_prev = inst_req_o.req & ack;
    acc_addr = inst_req_o.addr;
  endtask

  initial begin
    tests_run     = 0;
    tests_failed  = 0;
    acc_prev      = 1'b0;
    acc_addr      = 32'd0;
    rst_neg_ni    = 1'b0;
    fetch_en_i    = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'd0;
    inst_ack_i    = '0;
    ifq_ready_i   = 1'b0;

    repeat (2) @(negedge clk_neg_i);
    #1;
    chk("rst_req",   {31'd0, inst_req_o.req}, 32'd0);
    chk("rst_addr",  inst_req_o.addr, 32'h8000_0000);
    chk("rst_valid", {31'd0, ifq_valid_o}, 32'd0);
    chk("rst_inst",  ifq_inst_o, 32'd0);
    chk("rst_pc",    ifq_pc_o, 32'd0);
    chk("rst_err",   {31'd0, ifq_err_o}, 32'd0);
    chk("rst_busy",  {31'd0, busy_o}, 32'd0);
    rst_neg_ni = 1'b1;

    // c0: fetch disabled
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
    chk("c0_req", {31'd0, inst_req_o.req}, 32'd0);
    // c1..c2: first two accepts
    step(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
    chk("c1_req",  {31'd0, inst_req_o.req}, 32'd1);
    chk("c1_addr", inst_req_o.addr, 32'h8000_0000);
    step(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
    chk("c2_addr",  inst_req_o.addr, 32'h8000_0004);
    chk("c2_valid", {31'd0, ifq_valid_o}, 32'd0);
    // c3..c4: stall at 8000_0008
    step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    chk("c3_valid", {31'd0, ifq_valid_o}, 32'd1);
    chk("c3_pc",    ifq_pc_o, 32'h8000_0000);
    chk("c3_inst",  ifq_inst_o, 32'h9357_9BDF);
    chk("c3_addr",  inst_req_o.addr, 32'h8000_0008);
    step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    chk("c4_req",  {31'd0, inst_req_o.req}, 32'd1);
    chk("c4_addr", inst_req_o.addr, 32'h8000_0008);
    chk("c4_pc",   ifq_pc_o, 32'h8000_0004);
    step(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
    chk("c5_addr",  inst_req_o.addr, 32'h8000_0008);
    chk("c5_valid", {31'd0, ifq_valid_o}, 32'd0);
    step(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
    chk("c6_addr", inst_req_o.addr, 32'h8000_000C);
    // c7: errored accept at 8000_0010
    step(1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 1'b1);
    chk("c7_pc",   ifq_pc_o, 32'h8000_0008);
    chk("c7_addr", inst_req_o.addr, 32'h8000_0010);
    step(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
    chk("c8_pc",  ifq_pc_o, 32'h8000_000C);
    chk("c8_err", {31'd0, ifq_err_o}, 32'd0);
    // c9..c10: backpressure saturates the queue
    step(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    chk("c9_pc",   ifq_pc_o, 32'h8000_0010);
    chk("c9_inst", ifq_inst_o, 32'h9357_9BCF);
    chk("c9_err",  {31'd0, ifq_err_o}, ERR_EXP);
    chk("c9_req",  {31'd0, inst_req_o.req}, 32'd0);
    step(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    chk("c10_req",   {31'd0, inst_req_o.req}, 32'd0);
    chk("c10_valid", {31'd0, ifq_valid_o}, 32'd1);
    chk("c10_pc",    ifq_pc_o, 32'h8000_0010);
    step(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
    chk("c11_req",  {31'd0, inst_req_o.req}, 32'd1);
    chk("c11_addr", inst_req_o.addr, 32'h8000_0018);
    step(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
    chk("c12_pc",   ifq_pc_o, 32'h8000_0014);
    chk("c12_err",  {31'd0, ifq_err_o}, 32'd0);
    chk("c12_addr", inst_req_o.addr, 32'h8000_001C);
    // c13: redirect one cycle after the accept of 8000_001C
    step(1'b1, 1'b1, 32'h0000_0102, 1'b1, 1'b0, 1'b1);
    chk("c13_req", {31'd0, inst_req_o.req}, 32'd0);
    chk("c13_pc",  ifq_pc_o, 32'h8000_0018);
    step(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
    chk("c14_valid", {31'd0, ifq_valid_o}, 32'd0);
    chk("c14_req",   {31'd0, inst_req_o.req}, 32'd1);
    chk("c14_addr",  inst_req_o.addr, 32'h0000_0100);
    // c15: redirect to the top of the address space
    step(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b1);
    chk("c15_valid", {31'd0, ifq_valid_o}, 32'd0);
    chk("c15_req",   {31'd0, inst_req_o.req}, 32'd0);
    step(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
    chk("c16_addr", inst_req_o.addr, 32'hFFFF_FFFC);
    step(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
    chk("c17_addr", inst_req_o.addr, 32'h0000_0000);
    // c18..c20: fetch disabled, queue drains
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
    chk("c18_pc",   ifq_pc_o, 32'hFFFF_FFFC);
    chk("c18_inst", ifq_inst_o, 32'hECA8_6423);
    chk("c18_req",  {31'd0, inst_req_o.req}, 32'd0);
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
    chk("c19_pc",   ifq_pc_o, 32'h0000_0000);
    chk("c19_busy", {31'd0, busy_o}, 32'd1);
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
    chk("c20_valid", {31'd0, ifq_valid_o}, 32'd0);
    chk("c20_busy",  {31'd0, busy_o}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
